// File: rtl/sumsq_accum_pkg.sv
// Shared definitions for the sum-of-squares feeder.
// Holds the FSM state encoding, a constant clog2 helper and the
// minimum radicand width used by the elaboration-time check.
package sumsq_accum_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_MUL   = 2'd1;
  localparam state_t S_ACC   = 2'd2;
  localparam state_t S_ISSUE = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Smallest radicand width that holds n squares of dw-bit values exactly.
  function automatic int rw_min(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

endpackage

// File: rtl/sumsq_accum_seq_square.sv
// Sequential shift-add squarer, LSB-first, one multiplier bit per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture din as multiplicand and multiplier, start
//   din       : DW-bit unsigned operand
//   busy      : high for exactly DW cycles after load
//   done      : high in the final step cycle; product is final the
//               cycle after done
//   product   : 2*DW-bit result register
module sumsq_accum_seq_square
  import sumsq_accum_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DW-1:0]   din,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int KW = (DW > 1) ? clog2(DW) : 1;

  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [KW-1:0]   k;

  assign done = busy && (k == KW'(DW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      k       <= '0;
      product <= '0;
    end else if (load) begin
      mcand   <= {{DW{1'b0}}, din};
      mplier  <= din;
      product <= '0;
      k       <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) product <= product + (mcand << k);
      mplier <= mplier >> 1;
      k      <= k + KW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/sumsq_accum.sv
// Sum-of-squares feeder for the iterative square-root unit.
// Accepts N unsigned components, squares each sequentially, accumulates
// them, then issues one start pulse with the radicand once the root unit
// is idle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : component present on in_data
//   in_ready   : component accepted this cycle when in_valid is high
//   in_data    : DW-bit unsigned component
//   sqrt_busy  : root unit busy; holds off issue
//   out_start  : one-cycle start pulse
//   out_rad    : radicand, held between issues
//   vec_count  : components accumulated in the current vector
module sumsq_accum
  import sumsq_accum_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 3,
  parameter int RW = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             sqrt_busy,
  output logic             out_start,
  output logic [RW-1:0]    out_rad,
  output logic [clog2(N):0] vec_count
);

  localparam int CW = clog2(N) + 1;

  generate
    if ((RW < rw_min(DW, N)) || (RW % 2 != 0) || (N < 1)) begin : g_bad_cfg
      $error("sumsq_accum: RW must be even and >= 2*DW+clog2(N), N >= 1");
    end
  endgenerate

  state_t          state;
  logic [RW-1:0]   acc;
  logic [CW-1:0]   count;
  logic            load;
  logic            sq_busy;
  logic            sq_done;
  logic [2*DW-1:0] product;

  assign in_ready  = (state == S_IDLE) && !sq_busy;
  assign load      = in_valid && in_ready;
  assign vec_count = count;

  sumsq_accum_seq_square #(.DW(DW)) u_sq (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (in_data),
    .busy    (sq_busy),
    .done    (sq_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      out_start <= 1'b0;
      out_rad   <= '0;
    end else begin
      out_start <= 1'b0;
      case (state)
        S_IDLE:  if (load) state <= S_MUL;
        S_MUL:   if (sq_done) state <= S_ACC;
        S_ACC: begin
          acc   <= acc + RW'(product);
          count <= count + CW'(1);
          state <= (count + CW'(1) == CW'(N)) ? S_ISSUE : S_IDLE;
        end
        S_ISSUE: begin
          // Pulse and radicand are registered together so the root unit
          // sees them in the same cycle.
          if (!sqrt_busy) begin
            out_start <= 1'b1;
            out_rad   <= acc;
            acc       <= '0;
            count     <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sumsq_accum.sv
module tb_sumsq_accum;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=3 instance
  logic          v0 = 1'b0, b0 = 1'b0;
  logic [7:0]    d0 = '0;
  logic          rdy0, st0;
  logic [17:0]   rad0;
  logic [2:0]    vc0;

  // N=1 instance
  logic          v1 = 1'b0, b1 = 1'b0;
  logic [7:0]    d1 = '0;
  logic          rdy1, st1;
  logic [15:0]   rad1;
  logic [0:0]    vc1;

  sumsq_accum #(.DW(8), .N(3), .RW(18)) dut (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .sqrt_busy(b0), .out_start(st0), .out_rad(rad0), .vec_count(vc0));

  sumsq_accum #(.DW(8), .N(1), .RW(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .sqrt_busy(b1), .out_start(st1), .out_rad(rad1), .vec_count(vc1));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a component occupies the block for DW+1
  // cycles after acceptance; its square joins the sum at the end of that
  // window; a full vector then waits for sqrt_busy low and is issued.
  typedef struct {
    int phase;   // 0 ready, 1 squaring, 2 waiting to issue
    int timer;
    int pend;
    int sum;
    int cnt;
    int start;
    int rad;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit r, input bit v,
                                input int d, input bit b, input int n);
    mdl_t o;
    o = m;
    o.start = 0;
    if (r) begin
      o = '{default: 0};
      return o;
    end
    case (m.phase)
      0: if (v) begin o.pend = d * d; o.timer = DW + 1; o.phase = 1; end
      1: begin
        o.timer = o.timer - 1;
        if (o.timer == 0) begin
          o.sum = o.sum + o.pend;
          o.cnt = o.cnt + 1;
          o.phase = (o.cnt == n) ? 2 : 0;
        end
      end
      default: if (!b) begin
        o.start = 1; o.rad = o.sum; o.sum = 0; o.cnt = 0; o.phase = 0;
      end
    endcase
    return o;
  endfunction

  mdl_t m0 = '{default: 0};
  mdl_t m1 = '{default: 0};

  always @(posedge clk) begin
    m0 <= step(m0, rst, v0, int'(d0), b0, 3);
    m1 <= step(m1, rst, v1, int'(d1), b1, 1);
  end

  int q0[$];
  int q1[$];

  always @(negedge clk) begin
    if (st0) q0.push_back(int'(rad0));
    if (st1) q1.push_back(int'(rad1));
    if (chk_en) begin
      chk("ready0", int'(rdy0), int'(m0.phase == 0));
      chk("start0", int'(st0), m0.start);
      chk("rad0",   int'(rad0), m0.rad);
      chk("vcnt0",  int'(vc0), m0.cnt);
      chk("ready1", int'(rdy1), int'(m1.phase == 0));
      chk("start1", int'(st1), m1.start);
      chk("rad1",   int'(rad1), m1.rad);
      chk("vcnt1",  int'(vc1), m1.cnt);
    end
  end

  task automatic send0(input int d);
    bit got;
    got = 1'b0;
    v0 = 1'b1; d0 = 8'(d);
    for (int i = 0; i < 200 && !got; i++) begin
      got = rdy0;
      @(negedge clk);
    end
    v0 = 1'b0;
    if (!got) chk("send0_timeout", 0, 1);
  endtask

  task automatic send1(input int d);
    bit got;
    got = 1'b0;
    v1 = 1'b1; d1 = 8'(d);
    for (int i = 0; i < 200 && !got; i++) begin
      got = rdy1;
      @(negedge clk);
    end
    v1 = 1'b0;
    if (!got) chk("send1_timeout", 0, 1);
  endtask

  task automatic wait_q0(input int n);
    for (int i = 0; i < 400 && q0.size() < n; i++) @(negedge clk);
    if (q0.size() < n) chk("issue0_timeout", q0.size(), n);
  endtask

  task automatic wait_q1(input int n);
    for (int i = 0; i < 400 && q1.size() < n; i++) @(negedge clk);
    if (q1.size() < n) chk("issue1_timeout", q1.size(), n);
  endtask

  int exp0[6] = '{25, 195075, 9, 25, 9, 0};
  int exp1[2] = '{49, 0};

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // (3,4,0) -> 25
    send0(3); send0(4); send0(0);
    wait_q0(1);

    // all max, sqrt_busy toggling while squaring
    b0 = 1'b1; send0(255);
    b0 = 1'b0; send0(255);
    b0 = 1'b1; send0(255);
    repeat (3) @(negedge clk);
    b0 = 1'b0;
    wait_q0(2);

    // (1,2,2) with issue held off by sqrt_busy
    send0(1); send0(2);
    b0 = 1'b1; send0(2);
    repeat (DW + 1 + 10) @(negedge clk);
    chk("held_no_issue", q0.size(), 2);
    b0 = 1'b0;
    wait_q0(3);

    // back-to-back components over two vectors
    send0(3); send0(4); send0(0); send0(1); send0(2); send0(2);
    wait_q0(5);

    // reset mid-multiply of second component
    send0(5); send0(5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("vcnt_after_rst", int'(vc0), 0);
    chk("ready_after_rst", int'(rdy0), 1);
    send0(0); send0(0); send0(0);
    wait_q0(6);

    // reset lands on the issue cycle with sqrt_busy low: no pulse
    send0(9); send0(9); send0(9);
    repeat (DW + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("start_on_rst", int'(st0), 0);
    repeat (20) @(negedge clk);
    chk("issues0", q0.size(), 6);

    // N=1 build
    send1(7);
    wait_q1(1);
    send1(0);
    wait_q1(2);
    repeat (5) @(negedge clk);
    chk("issues1", q1.size(), 2);

    for (int i = 0; i < 6; i++)
      if (i < q0.size()) chk($sformatf("rad0_lit%0d", i), q0[i], exp0[i]);
    for (int i = 0; i < 2; i++)
      if (i < q1.size()) chk($sformatf("rad1_lit%0d", i), q1[i], exp1[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
